// File: rtl/bnn_pkg.sv
// Shared types and elaboration helpers for the binary neural layer.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int unsigned DEF_TH = 7;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Threshold / popcount width able to hold 0..n_in.
    function automatic int unsigned th_w(input int unsigned n_in);
        return clog2(n_in + 1);
    endfunction

    function automatic int unsigned wb_cnt(input int unsigned n_in, input int unsigned ld_w);
        return ceil_div(n_in, ld_w);
    endfunction

    function automatic int unsigned tb_cnt(input int unsigned n_in, input int unsigned ld_w);
        return ceil_div(th_w(n_in), ld_w);
    endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Load port, activation input stream and result output stream of one layer.
interface bnn_layer_seq_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned LD_W  = 4
) ();
    logic              ena;
    logic              ld_en;
    logic              ld_rst;
    logic [LD_W-1:0]   ld_data;
    logic              ld_done;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic              busy;

    modport master (
        output ena, ld_en, ld_rst, ld_data, in_valid, in_data, out_ready,
        input  ld_done, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  ena, ld_en, ld_rst, ld_data, in_valid, in_data, out_ready,
        output ld_done, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/bnn_xnor_popcount.sv
// Counts matching bits between an activation vector and one weight row.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned N_IN = 8
) (
    input  logic [N_IN-1:0]           x_i,
    input  logic [N_IN-1:0]           w_i,
    output logic [th_w(N_IN)-1:0]     cnt_o
);
    localparam int unsigned TH_W = th_w(N_IN);

    logic [N_IN-1:0] match;

    always_comb begin
        match = ~(x_i ^ w_i);
        cnt_o = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            cnt_o = cnt_o + TH_W'(match[0]);
            match = match >> 1;
        end
    end
endmodule

// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binary layer: one XNOR-popcount neuron evaluated per cycle,
// weights and thresholds loaded beat-serially while idle.
module bnn_layer_seq #(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned LD_W   = 4,
    parameter int unsigned DEF_TH = bnn_pkg::DEF_TH
) (
    input  logic             clk,
    input  logic             rst_n,
    bnn_layer_seq_if.slave   bus
);
    import bnn_pkg::*;

    localparam int unsigned TH_W = th_w(N_IN);
    localparam int unsigned WB   = wb_cnt(N_IN, LD_W);
    localparam int unsigned TB   = tb_cnt(N_IN, LD_W);
    localparam int unsigned NB   = WB + TB;
    localparam int unsigned BW   = (NB > 1) ? clog2(NB) : 1;
    localparam int unsigned NW   = (N_OUT > 1) ? clog2(N_OUT) : 1;

    state_e            state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [N_OUT-1:0]  res_q, res_d;
    logic              out_valid_q, out_valid_d;
    logic [NW-1:0]     ld_n_q, ld_n_d;
    logic [BW-1:0]     ld_b_q, ld_b_d;
    logic              ld_done_q, ld_done_d;
    logic [N_IN-1:0]   w_q  [N_OUT];
    logic [N_IN-1:0]   w_d  [N_OUT];
    logic [TH_W-1:0]   th_q [N_OUT];
    logic [TH_W-1:0]   th_d [N_OUT];

    logic [N_IN-1:0]   w_bits, w_mask;
    logic [TH_W-1:0]   th_bits, th_mask;
    logic [TH_W-1:0]   pc;
    logic              ptr_zero;
    logic              in_ready_c;

    // Spread the current beat over the row bits it owns; bits past the row are dropped.
    for (genvar i = 0; i < int'(N_IN); i++) begin : g_wmask
        assign w_bits[i] = bus.ld_data[i % LD_W];
        assign w_mask[i] = (ld_b_q == BW'(i / LD_W));
    end
    for (genvar i = 0; i < int'(TH_W); i++) begin : g_tmask
        assign th_bits[i] = bus.ld_data[i % LD_W];
        assign th_mask[i] = (ld_b_q == BW'(WB + i / LD_W));
    end

    bnn_xnor_popcount #(.N_IN(N_IN)) u_pc (
        .x_i   (x_q),
        .w_i   (w_q[n_q]),
        .cnt_o (pc)
    );

    assign ptr_zero   = (ld_n_q == '0) && (ld_b_q == '0);
    assign in_ready_c = bus.ena && !bus.ld_en && ptr_zero && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        x_d         = x_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        ld_n_d      = ld_n_q;
        ld_b_d      = ld_b_q;
        ld_done_d   = 1'b0;
        w_d         = w_q;
        th_d        = th_q;

        if (bus.ena) begin
            if (bus.ld_rst) begin
                ld_n_d = '0;
                ld_b_d = '0;
            end else if (bus.ld_en && (state_q == IDLE)) begin
                w_d[ld_n_q]  = (w_q[ld_n_q] & ~w_mask) | (w_bits & w_mask);
                th_d[ld_n_q] = (th_q[ld_n_q] & ~th_mask) | (th_bits & th_mask);
                if (ld_b_q == BW'(NB - 1)) begin
                    ld_b_d = '0;
                    if (ld_n_q == NW'(N_OUT - 1)) begin
                        ld_n_d    = '0;
                        ld_done_d = 1'b1;
                    end else begin
                        ld_n_d = ld_n_q + 1'b1;
                    end
                end else begin
                    ld_b_d = ld_b_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_c) begin
                        x_d     = bus.in_data;
                        res_d   = '0;
                        n_d     = '0;
                        state_d = COMPUTE;
                    end
                end
                COMPUTE: begin
                    res_d[n_q] = (pc >= th_q[n_q]);
                    n_d        = n_q + 1'b1;
                    if (n_q == NW'(N_OUT - 1)) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            x_q         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            ld_n_q      <= '0;
            ld_b_q      <= '0;
            ld_done_q   <= 1'b0;
            w_q         <= '{default: '0};
            th_q        <= '{default: TH_W'(DEF_TH)};
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            x_q         <= x_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            ld_n_q      <= ld_n_d;
            ld_b_q      <= ld_b_d;
            ld_done_q   <= ld_done_d;
            w_q         <= w_d;
            th_q        <= th_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.ld_done   = ld_done_q && bus.ena;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
